// File: rtl/fdivsqrt_iter.sv
// Iterative IEEE-754 divide / square-root unit.
// Radix-2 digit recurrence: one quotient/root bit per cycle, valid/ready
// handshake on both sides, five RISC-V rounding modes, fflags output.
// Subnormal inputs are flushed to signed zero; results never go subnormal.
module fdivsqrt_iter #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_op,
  input  logic [2:0]       i_rm,
  input  logic [EW+MW:0]   i_a,
  input  logic [EW+MW:0]   i_b,
  input  logic             i_kill,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [EW+MW:0]   o_res,
  output logic [4:0]       o_flags
);

  localparam int FLEN = 1 + EW + MW;
  localparam int XW   = EW + 2;          // signed exponent width
  localparam int QW   = MW + 3;          // hidden + mantissa + guard + round
  localparam int RW   = MW + 6;          // partial remainder width
  localparam int SW   = 2 * QW;          // sqrt radicand width (2 bits per step)
  localparam int CW   = $clog2(QW);

  localparam logic signed [XW-1:0] BIAS_S  = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EW) - 1);
  localparam logic [EW-1:0]        EXP_ONES = '1;
  localparam logic [FLEN-1:0]      CNAN = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_e;

  state_e               state_q;
  logic                 op_q;
  logic [2:0]           rm_q;
  logic [FLEN-1:0]      a_q, b_q;
  logic                 sign_q;
  logic signed [XW-1:0] exp_q;
  logic [QW-1:0]        q_q;
  logic [RW-1:0]        rem_q;
  logic [MW:0]          div_q;
  logic [SW-1:0]        x_q;
  logic [CW-1:0]        cnt_q;
  logic                 o_valid_q;
  logic [FLEN-1:0]      res_q;
  logic [4:0]           flags_q;

  assign o_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_res   = res_q;
  assign o_flags = flags_q;

  // ---------------------------------------------------------------------------
  // Operand unpack (subnormals read as zero because their exponent field is 0)
  // ---------------------------------------------------------------------------
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic [MW:0]   ma, mb;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign sa     = a_q[FLEN-1];
  assign sb     = b_q[FLEN-1];
  assign ea     = a_q[FLEN-2:MW];
  assign eb     = b_q[FLEN-2:MW];
  assign fa     = a_q[MW-1:0];
  assign fb     = b_q[MW-1:0];
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_snan = a_nan && !fa[MW-1];
  assign b_snan = b_nan && !fb[MW-1];

  // ---------------------------------------------------------------------------
  // PREP: special-case resolution and recurrence setup
  // ---------------------------------------------------------------------------
  logic                 p_special, p_sign, a_lt, e_odd;
  logic [FLEN-1:0]      p_res;
  logic [4:0]           p_flags;
  logic signed [XW-1:0] p_exp, ea_s, eb_s, e_unb, e_even;
  logic [RW-1:0]        p_rem;
  logic [SW-1:0]        p_x;
  logic [MW+1:0]        sq_m;

  // Classify operands and compute the starting exponent/remainder/radicand.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    p_special = 1'b0;
    p_res     = '0;
    p_flags   = '0;
    p_sign    = 1'b0;
    p_exp     = '0;
    p_rem     = '0;
    p_x       = '0;
    a_lt      = 1'b0;
    sq_m      = '0;
    ea_s      = XW'(ea);
    eb_s      = XW'(eb);
    e_unb     = ea_s - BIAS_S;
    e_odd     = e_unb[0];
    e_even    = e_unb - XW'(e_odd);
    if (!op_q) begin
      p_sign = sa ^ sb;
      if (a_nan || b_nan) begin
        p_special = 1'b1;
        p_res     = CNAN;
        p_flags   = {a_snan || b_snan, 4'b0000};
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        p_special = 1'b1;
        p_res     = CNAN;
        p_flags   = 5'b10000;
      end else if (a_inf) begin
        p_special = 1'b1;
        p_res     = {p_sign, EXP_ONES, {MW{1'b0}}};
      end else if (b_zero) begin
        p_special = 1'b1;
        p_res     = {p_sign, EXP_ONES, {MW{1'b0}}};
        p_flags   = 5'b01000;
      end else if (a_zero || b_inf) begin
        p_special = 1'b1;
        p_res     = {p_sign, {(EW+MW){1'b0}}};
      end else begin
        // Pre-normalise so the quotient lands in [1,2).
        a_lt  = (ma < mb);
        p_rem = a_lt ? RW'({ma, 1'b0}) : RW'(ma);
        p_exp = ea_s - eb_s + BIAS_S - XW'(a_lt);
      end
    end else begin
      p_sign = sa;
      if (a_nan) begin
        p_special = 1'b1;
        p_res     = CNAN;
        p_flags   = {a_snan, 4'b0000};
      end else if (a_zero) begin
        p_special = 1'b1;
        p_res     = {sa, {(EW+MW){1'b0}}};
      end else if (sa) begin
        p_special = 1'b1;
        p_res     = CNAN;
        p_flags   = 5'b10000;
      end else if (a_inf) begin
        p_special = 1'b1;
        p_res     = {1'b0, EXP_ONES, {MW{1'b0}}};
      end else begin
        // Odd exponent: fold one factor of two into the radicand.
        sq_m  = e_odd ? {ma, 1'b0} : {1'b0, ma};
        p_x   = {sq_m, {(MW+4){1'b0}}};
        p_exp = (e_even >>> 1) + BIAS_S;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ITER: one restoring division / square-root step
  // ---------------------------------------------------------------------------
  logic          it_ge;
  logic [RW-1:0] it_rem, sq_sh, sq_trial;

  // Produce the next quotient/root bit and partial remainder.
  always_comb begin
    it_ge    = 1'b0;
    it_rem   = rem_q;
    sq_sh    = '0;
    sq_trial = '0;
    if (!op_q) begin
      it_ge  = (rem_q >= RW'(div_q));
      it_rem = it_ge ? ((rem_q - RW'(div_q)) << 1) : (rem_q << 1);
    end else begin
      sq_sh    = {rem_q[RW-3:0], x_q[SW-1 -: 2]};
      sq_trial = RW'({q_q, 2'b01});
      it_ge    = (sq_sh >= sq_trial);
      it_rem   = it_ge ? (sq_sh - sq_trial) : sq_sh;
    end
  end

  // ---------------------------------------------------------------------------
  // ROUND: round, detect overflow/underflow, pack
  // ---------------------------------------------------------------------------
  logic                 g_bit, r_bit, st_bit, lsb_bit, inexact, inc, of, uf, ovf_inf;
  logic [2:0]           rm_eff;
  logic [MW+1:0]        mant_r;
  logic signed [XW-1:0] exp_r;
  logic [FLEN-1:0]      r_res;
  logic [4:0]           r_flags;

  // Apply the rounding mode to the MW+3 bit result plus sticky.
  always_comb begin
    g_bit   = q_q[1];
    r_bit   = q_q[0];
    st_bit  = (rem_q != '0);
    lsb_bit = q_q[2];
    inexact = g_bit | r_bit | st_bit;
    rm_eff  = (rm_q > 3'd4) ? 3'd0 : rm_q;
    case (rm_eff)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & inexact;
      3'd3:    inc = ~sign_q & inexact;
      3'd4:    inc = g_bit;
      default: inc = g_bit & (r_bit | st_bit | lsb_bit);
    endcase
    mant_r  = {1'b0, q_q[QW-1:2]} + (MW+2)'(inc);
    exp_r   = exp_q + XW'(mant_r[MW+1]);
    of      = (exp_r >= EXP_MAX);
    uf      = exp_r[XW-1] || (exp_r == '0);
    ovf_inf = (rm_eff == 3'd0) || (rm_eff == 3'd4) ||
              (rm_eff == 3'd3 && !sign_q) || (rm_eff == 3'd2 && sign_q);
    if (of) begin
      r_res   = ovf_inf ? {sign_q, EXP_ONES, {MW{1'b0}}}
                        : {sign_q, EXP_ONES - EW'(1), {MW{1'b1}}};
      r_flags = 5'b00101;
    end else if (uf) begin
      r_res   = {sign_q, {(EW+MW){1'b0}}};
      r_flags = 5'b00011;
    end else begin
      r_res   = {sign_q, exp_r[EW-1:0], mant_r[MW-1:0]};
      r_flags = {4'b0000, inexact};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and all state registers
  // ---------------------------------------------------------------------------
  // Sequence IDLE->PREP->ITER->ROUND->DONE, with kill/reset returning to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: only control and output registers are reset; operand/datapath registers are always loaded before being read.
    if (rst) begin
      state_q   <= IDLE;
      o_valid_q <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
    end else if (i_kill) begin
      state_q   <= IDLE;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            op_q    <= i_op;
            rm_q    <= i_rm;
            a_q     <= i_a;
            b_q     <= i_b;
            state_q <= PREP;
          end
        end
        PREP: begin
          if (p_special) begin
            res_q     <= p_res;
            flags_q   <= p_flags;
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            sign_q  <= p_sign;
            exp_q   <= p_exp;
            rem_q   <= p_rem;
            div_q   <= mb;
            x_q     <= p_x;
            q_q     <= '0;
            cnt_q   <= CW'(QW - 1);
            state_q <= ITER;
          end
        end
        ITER: begin
          q_q   <= {q_q[QW-2:0], it_ge};
          rem_q <= it_rem;
          x_q   <= x_q << 2;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= ROUND;
        end
        ROUND: begin
          res_q     <= r_res;
          flags_q   <= r_flags;
          o_valid_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
